// File: rtl/wm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wm_port_arbiter
// Purpose  : Shares the single weight-memory port between the core read
//            engine and the host Avalon-MM slave. At most one access is
//            issued per cycle. Read data is routed back to the requester.
//            A starvation counter force-grants the host after STARVE_MAX
//            consecutive cycles of being blocked by the core.
// Ports    : clk, rst              - clock, asynchronous active-high reset
//            host_*                - Avalon-MM style host command/response
//            host_err / err_clr    - sticky illegal-command flag and clear
//            core_ren/addr/gnt     - core read request and grant
//            core_rdata/rvalid     - core read response
//            mem_*                 - weight memory port (MEM_LAT read latency)
// Optional : `define WM_ARB_STATS_EN adds conflict_cnt, force_cnt, stats_clr
// Revision : 1.0 - initial release
// ============================================================================
module wm_port_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 512,
    parameter int BEW        = DW / 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    // host slave
    input  logic [AW-1:0]  host_addr,
    input  logic [DW-1:0]  host_wdata,
    input  logic [BEW-1:0] host_be,
    input  logic           host_cs,
    input  logic           host_r,
    input  logic           host_w,
    output logic           host_waitrequest,
    output logic [DW-1:0]  host_rdata,
    output logic           host_rvalid,
    output logic           host_err,
    // core read engine
    input  logic           core_ren,
    input  logic [AW-1:0]  core_addr,
    output logic           core_gnt,
    output logic [DW-1:0]  core_rdata,
    output logic           core_rvalid,
    input  logic           err_clr,
`ifdef WM_ARB_STATS_EN
    output logic [31:0]    conflict_cnt,
    output logic [31:0]    force_cnt,
    input  logic           stats_clr,
`endif
    // weight memory
    output logic           mem_ena,
    output logic [BEW-1:0] mem_wea,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_q
);

    localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

    logic               w_host_req;
    logic               w_illegal;
    logic               w_force;
    logic               w_core_gnt;
    logic               w_host_gnt;
    logic               w_rd_issue;
    logic [7:0]         r_starve_cnt;
    logic [MEM_LAT-1:0] r_pipe_vld;
    logic [MEM_LAT-1:0] r_pipe_own;   // 1 = host, 0 = core

    // ------------------------------------------------------------------
    // Request decode and grant
    // ------------------------------------------------------------------
    assign w_host_req = host_cs & (host_r ^ host_w);
    assign w_illegal  = host_cs & host_r & host_w;
    assign w_force    = w_host_req & (r_starve_cnt == c_starve_max);

    // Grants are gated by rst so the memory port is quiet while in reset.
    assign w_core_gnt = ~rst & ~w_force & core_ren;
    assign w_host_gnt = ~rst & (w_force | (~core_ren & w_host_req));
    assign w_rd_issue = w_core_gnt | (w_host_gnt & host_r);

    assign core_gnt         = w_core_gnt;
    // Illegal commands are swallowed so the host never stalls on them.
    assign host_waitrequest = rst | ~(w_host_gnt | w_illegal);

    // ------------------------------------------------------------------
    // Memory drive
    // ------------------------------------------------------------------
    assign mem_ena   = w_core_gnt | w_host_gnt;
    assign mem_wea   = (w_host_gnt & host_w) ? host_be : '0;
    assign mem_addr  = w_core_gnt ? core_addr : host_addr;
    assign mem_wdata = host_wdata;

    // ------------------------------------------------------------------
    // Starvation counter: counts cycles where the host waits behind the
    // core; any other situation (host served or idle) restarts it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_host_req & w_core_gnt) begin
            if (r_starve_cnt != c_starve_max)
                r_starve_cnt <= r_starve_cnt + 8'd1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky illegal-command flag (set beats clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            host_err <= 1'b0;
        else if (w_illegal)
            host_err <= 1'b1;
        else if (err_clr)
            host_err <= 1'b0;
    end

    // ------------------------------------------------------------------
    // Return path: {valid, owner} travels alongside the memory latency so
    // the last stage lines up with mem_q.
    // ------------------------------------------------------------------
    generate
        if (MEM_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipe_vld <= '0;
                    r_pipe_own <= '0;
                end else begin
                    r_pipe_vld <= w_rd_issue;
                    r_pipe_own <= w_host_gnt;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipe_vld <= '0;
                    r_pipe_own <= '0;
                end else begin
                    r_pipe_vld <= {r_pipe_vld[MEM_LAT-2:0], w_rd_issue};
                    r_pipe_own <= {r_pipe_own[MEM_LAT-2:0], w_host_gnt};
                end
            end
        end
    endgenerate

    assign core_rvalid = r_pipe_vld[MEM_LAT-1] & ~r_pipe_own[MEM_LAT-1];
    assign host_rvalid = r_pipe_vld[MEM_LAT-1] &  r_pipe_own[MEM_LAT-1];
    assign core_rdata  = mem_q;
    assign host_rdata  = mem_q;

`ifdef WM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_force_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_force_cnt    <= '0;
        end else if (stats_clr) begin
            r_conflict_cnt <= '0;
            r_force_cnt    <= '0;
        end else begin
            if (core_ren & w_host_req & (r_conflict_cnt != 32'hFFFF_FFFF))
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (w_force & (r_force_cnt != 32'hFFFF_FFFF))
                r_force_cnt <= r_force_cnt + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign force_cnt    = r_force_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_port_arbiter
// Purpose  : Self-checking bench for wm_port_arbiter. Directed stimulus
//            pushes expected read responses into a scoreboard; a monitor
//            pops and compares on every rvalid (owner, data, arrival cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wm_port_arbiter;

    localparam int c_aw         = 11;
    localparam int c_dw         = 512;
    localparam int c_bew        = c_dw / 8;
    localparam int c_mem_lat    = 1;
    localparam int c_starve_max = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [c_aw-1:0]  host_addr = '0;
    logic [c_dw-1:0]  host_wdata = '0;
    logic [c_bew-1:0] host_be = '0;
    logic             host_cs = 1'b0, host_r = 1'b0, host_w = 1'b0;
    logic             host_waitrequest, host_rvalid, host_err;
    logic [c_dw-1:0]  host_rdata;
    logic             core_ren = 1'b0;
    logic [c_aw-1:0]  core_addr = '0;
    logic             core_gnt, core_rvalid;
    logic [c_dw-1:0]  core_rdata;
    logic             err_clr = 1'b0;
    logic             mem_ena;
    logic [c_bew-1:0] mem_wea;
    logic [c_aw-1:0]  mem_addr;
    logic [c_dw-1:0]  mem_wdata;
    logic [c_dw-1:0]  mem_q;
`ifdef WM_ARB_STATS_EN
    logic [31:0]      conflict_cnt, force_cnt;
    logic             stats_clr = 1'b0;
`endif

    wm_port_arbiter #(
        .AW(c_aw), .DW(c_dw), .BEW(c_bew),
        .MEM_LAT(c_mem_lat), .STARVE_MAX(c_starve_max)
    ) dut (
        .clk(clk), .rst(rst),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_be(host_be),
        .host_cs(host_cs), .host_r(host_r), .host_w(host_w),
        .host_waitrequest(host_waitrequest), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .host_err(host_err),
        .core_ren(core_ren), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .err_clr(err_clr),
`ifdef WM_ARB_STATS_EN
        .conflict_cnt(conflict_cnt), .force_cnt(force_cnt), .stats_clr(stats_clr),
`endif
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_q(mem_q)
    );

    // ------------------------------------------------------------------
    // Weight memory model: read-first, byte writes, c_mem_lat read latency
    // ------------------------------------------------------------------
    logic [c_dw-1:0] mem [0:(1<<c_aw)-1];
    logic [c_dw-1:0] qp  [c_mem_lat];
    assign mem_q = qp[c_mem_lat-1];

    function automatic logic [c_dw-1:0] pat(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(a);
        return {16{w}};
    endfunction

    initial for (int a = 0; a < (1 << c_aw); a++) mem[a] = pat(a);

    always @(posedge clk) begin
        for (int i = c_mem_lat - 1; i > 0; i--) qp[i] <= qp[i-1];
        qp[0] <= mem[mem_addr];
        if (mem_ena)
            for (int b = 0; b < c_bew; b++)
                if (mem_wea[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit              host;
        logic [c_dw-1:0] data;
        int              due;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkd(input string nm, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic push(input bit host, input int a);
        exp_t e;
        e.host = host;
        e.data = pat(a);
        e.due  = cyc + c_mem_lat;
        sb.push_back(e);
    endtask

    task automatic push_data(input bit host, input logic [c_dw-1:0] d);
        exp_t e;
        e.host = host;
        e.data = d;
        e.due  = cyc + c_mem_lat;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest outstanding grant.
    always @(negedge clk) begin
        exp_t e;
        if (core_rvalid && host_rvalid) chk("both_rvalid", 1, 0);
        if (core_rvalid || host_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, host_rvalid, core_rvalid}, 0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_owner", {63'd0, host_rvalid}, {63'd0, e.host});
                chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                chkd("rdata", e.host ? host_rdata : core_rdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    logic [c_dw-1:0] a5;

    initial begin
        a5 = {c_bew{8'hA5}};

        // Reset state, with a core request pending to prove it is masked
        core_ren = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_waitreq", host_waitrequest, 1);
        chk("rst_mem_ena", mem_ena, 0);
        chk("rst_mem_wea", mem_wea, 0);
        chk("rst_rvalids", {host_rvalid, core_rvalid}, 0);
        chk("rst_host_err", host_err, 0);
        core_ren = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Core only, addresses 0..7 back to back
        for (int a = 0; a < 8; a++) begin
            core_ren  = 1'b1;
            core_addr = c_aw'(a);
            @(negedge clk);
            chk("core_gnt", core_gnt, 1);
            chk("core_mem_addr", mem_addr, a);
            chk("core_mem_wea", mem_wea, 0);
            chk("idle_waitreq", host_waitrequest, 1);
            push(1'b0, a);
            step();
        end
        core_ren = 1'b0;
        repeat (3) step();

        // Host write then read of address 5
        host_cs = 1'b1; host_w = 1'b1; host_addr = 11'd5;
        host_be = '1; host_wdata = a5;
        @(negedge clk);
        chk("hw_waitreq", host_waitrequest, 0);
        chk("hw_mem_wea", mem_wea, {c_bew{1'b1}});
        chk("hw_mem_addr", mem_addr, 5);
        step();
        host_w = 1'b0; host_r = 1'b1;
        @(negedge clk);
        chk("hr_waitreq", host_waitrequest, 0);
        chk("hr_mem_wea", mem_wea, 0);
        chk("hr_mem_ena", mem_ena, 1);
        push_data(1'b1, a5);
        step();
        host_cs = 1'b0; host_r = 1'b0;
        repeat (3) step();

        // Starvation: core hogs the port while a host read waits
        host_cs = 1'b1; host_r = 1'b1; host_addr = 11'd9;
        core_ren = 1'b1;
        for (int i = 0; i < c_starve_max; i++) begin
            core_addr = c_aw'(20 + i);
            @(negedge clk);
            chk("starve_waitreq", host_waitrequest, 1);
            chk("starve_core_gnt", core_gnt, 1);
            push(1'b0, 20 + i);
            step();
        end
        core_addr = 11'd35;
        @(negedge clk);
        chk("force_waitreq", host_waitrequest, 0);
        chk("force_core_gnt", core_gnt, 0);
        chk("force_mem_addr", mem_addr, 9);
        push(1'b1, 9);
        step();
        host_cs = 1'b0; host_r = 1'b0;
        @(negedge clk);
        chk("resume_core_gnt", core_gnt, 1);
        chk("resume_mem_addr", mem_addr, 35);
        push(1'b0, 35);
        step();
        core_ren = 1'b0;
        repeat (3) step();

        // Interleave: alternating core and host reads
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                core_ren = 1'b1; core_addr = c_aw'(40 + i);
            end else begin
                host_cs = 1'b1; host_r = 1'b1; host_addr = c_aw'(60 + i);
            end
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("il_core_gnt", core_gnt, 1);
                push(1'b0, 40 + i);
            end else begin
                chk("il_host_wait", host_waitrequest, 0);
                chk("il_host_core_gnt", core_gnt, 0);
                push(1'b1, 60 + i);
            end
            step();
            core_ren = 1'b0; host_cs = 1'b0; host_r = 1'b0;
        end
        // Simultaneous requests: core wins, host follows next cycle
        core_ren = 1'b1; core_addr = 11'd50;
        host_cs = 1'b1; host_r = 1'b1; host_addr = 11'd51;
        @(negedge clk);
        chk("both_core_gnt", core_gnt, 1);
        chk("both_host_wait", host_waitrequest, 1);
        push(1'b0, 50);
        step();
        core_ren = 1'b0;
        @(negedge clk);
        chk("after_host_wait", host_waitrequest, 0);
        push(1'b1, 51);
        step();
        host_cs = 1'b0; host_r = 1'b0;
        repeat (3) step();

        // Illegal command: swallowed, flag set next cycle, then cleared
        host_cs = 1'b1; host_r = 1'b1; host_w = 1'b1; host_addr = 11'd7;
        @(negedge clk);
        chk("ill_waitreq", host_waitrequest, 0);
        chk("ill_mem_ena", mem_ena, 0);
        chk("ill_err_before", host_err, 0);
        step();
        host_cs = 1'b0; host_r = 1'b0; host_w = 1'b0;
        @(negedge clk);
        chk("ill_err_set", host_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("ill_err_clr", host_err, 0);
        // Set wins against clear in the same cycle
        host_cs = 1'b1; host_r = 1'b1; host_w = 1'b1; err_clr = 1'b1;
        step();
        host_cs = 1'b0; host_r = 1'b0; host_w = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        chk("ill_set_wins", host_err, 1);
        step();

        // Reset mid-flight: read granted, reset the following cycle
        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        host_cs = 1'b1; host_r = 1'b1; host_addr = 11'd70;
        @(negedge clk);
        chk("mf_grant", host_waitrequest, 0);
        step();
        core_ren = 1'b1; core_addr = 11'd71;
        rst = 1'b1;
        #1;
        chk("mf_core_gnt", core_gnt, 0);
        chk("mf_waitreq", host_waitrequest, 1);
        chk("mf_mem_ena", mem_ena, 0);
        chk("mf_rvalids", {host_rvalid, core_rvalid}, 0);
        chk("mf_host_err", host_err, 0);
        step();
        @(negedge clk);
        chk("mf_hold_mem_ena", mem_ena, 0);
        step();
        core_ren = 1'b0; host_cs = 1'b0; host_r = 1'b0;
        rst = 1'b0;
        repeat (6) step();

        // Every issued read must have returned
        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
